// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control unit: opcodes, FSM states, ALU op codes, status bits.
package sisc_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_LOD = 4'h2;
    localparam logic [3:0] OP_STR = 4'h3;
    localparam logic [3:0] OP_BRA = 4'h4;
    localparam logic [3:0] OP_BRR = 4'h5;
    localparam logic [3:0] OP_BNE = 4'h6;
    localparam logic [3:0] OP_BNR = 4'h7;
    localparam logic [3:0] OP_ALI = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        START,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } state_e;

    // alu_op[1] suppresses the status save, alu_op[0] selects the immediate as operand B
    localparam logic [1:0] ALUOP_REG  = 2'b00;
    localparam logic [1:0] ALUOP_IMM  = 2'b01;
    localparam logic [1:0] ALUOP_NONE = 2'b10;
    localparam logic [1:0] ALUOP_ADDR = 2'b11;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

endpackage

// File: rtl/sisc_ctrl_if.sv
// Control-unit bundle between sisc_ctrl (master) and the SISC datapath (slave).
interface sisc_ctrl_if;

    logic [31:0] instr;
    logic [3:0]  stat;
    logic [1:0]  alu_op;
    logic        ir_load;
    logic        pc_write;
    logic        pc_sel;
    logic        br_sel;
    logic        pc_rst;
    logic        rb_sel;
    logic        rf_we;
    logic        wb_sel;
    logic        dm_we;
    logic        halted;

    modport master (
        input  instr, stat,
        output alu_op, ir_load, pc_write, pc_sel, br_sel, pc_rst,
               rb_sel, rf_we, wb_sel, dm_we, halted
    );

    modport slave (
        output instr, stat,
        input  alu_op, ir_load, pc_write, pc_sel, br_sel, pc_rst,
               rb_sel, rf_we, wb_sel, dm_we, halted
    );

endinterface

// File: rtl/sisc_br_cond.sv
// Branch condition resolver: decides whether a branch opcode is taken given mask and status.
module sisc_br_cond
    import sisc_pkg::*;
#(
    parameter int OPW = 4,
    parameter int MMW = 4
) (
    input  logic [OPW-1:0] opcode_i,
    input  logic [MMW-1:0] mm_i,
    input  logic [3:0]     stat_i,
    output logic           taken_o
);

    logic maskHit;

    always_comb begin
        maskHit = |(mm_i & stat_i);
        taken_o = 1'b0;
        case (opcode_i)
            // an all-zero mask makes the positive-sense branches unconditional
            OP_BRA, OP_BRR: taken_o = (mm_i == '0) || maskHit;
            OP_BNE, OP_BNR: taken_o = !maskHit;
            default:        taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle control unit; every non-halt instruction walks FETCH..WRITEBACK in 5 cycles.
// Optional feature: define SISC_CTRL_IMM_ALU_EN to decode opcode 0x9 as ALU-immediate.
module sisc_ctrl
    import sisc_pkg::*;
#(
    parameter int OPW = 4,
    parameter int MMW = 4
) (
    input  logic         clk,
    input  logic         rst,
    sisc_ctrl_if.master  bus
);

    state_e         state_q, state_d;
    logic [OPW-1:0] opcode;
    logic [MMW-1:0] mm;
    logic           brTaken;
    logic           isStr;
    logic           isLod;
    logic           writesRf;
    logic [1:0]     aluOpInstr;
    logic           unusedInstrBits;

    assign opcode = bus.instr[31 -: OPW];
    assign mm     = bus.instr[31-OPW -: MMW];
    assign isStr  = (opcode == OP_STR);
    assign isLod  = (opcode == OP_LOD);

    // register numbers and immediate are consumed by the datapath, not here
    assign unusedInstrBits = ^bus.instr[31-OPW-MMW:0];

    sisc_br_cond #(
        .OPW (OPW),
        .MMW (MMW)
    ) u_br_cond (
        .opcode_i (opcode),
        .mm_i     (mm),
        .stat_i   (bus.stat),
        .taken_o  (brTaken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            START:     state_d = FETCH;
            FETCH:     state_d = DECODE;
            DECODE:    state_d = (opcode == OP_HLT) ? HALT : EXECUTE;
            EXECUTE:   state_d = MEM;
            MEM:       state_d = WRITEBACK;
            WRITEBACK: state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = START;
        endcase
    end

    always_comb begin
        aluOpInstr = ALUOP_NONE;
        writesRf   = 1'b0;
        case (opcode)
            OP_ALU: begin
                aluOpInstr = ALUOP_REG;
                writesRf   = 1'b1;
            end
            OP_LOD: begin
                aluOpInstr = ALUOP_ADDR;
                writesRf   = 1'b1;
            end
            OP_STR: aluOpInstr = ALUOP_ADDR;
`ifdef SISC_CTRL_IMM_ALU_EN
            OP_ALI: begin
                aluOpInstr = ALUOP_IMM;
                writesRf   = 1'b1;
            end
`endif
            default: aluOpInstr = ALUOP_NONE;
        endcase
    end

    // alu_op and rb_sel stay stable from EXECUTE to WRITEBACK so the registered ALU result matches
    always_comb begin
        bus.alu_op   = ALUOP_NONE;
        bus.ir_load  = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.br_sel   = 1'b0;
        bus.pc_rst   = 1'b0;
        bus.rb_sel   = 1'b0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.halted   = 1'b0;
        case (state_q)
            START: bus.pc_rst = 1'b1;
            FETCH: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
            end
            DECODE: bus.rb_sel = isStr;
            EXECUTE: begin
                bus.alu_op = aluOpInstr;
                bus.rb_sel = isStr;
            end
            MEM: begin
                bus.alu_op = aluOpInstr;
                bus.rb_sel = isStr;
                bus.dm_we  = isStr;
                if (brTaken) begin
                    bus.pc_write = 1'b1;
                    bus.pc_sel   = 1'b1;
                    bus.br_sel   = opcode[0];
                end
            end
            WRITEBACK: begin
                bus.alu_op = aluOpInstr;
                bus.rb_sel = isStr;
                bus.rf_we  = writesRf;
                bus.wb_sel = isLod;
            end
            HALT:    bus.halted = 1'b1;
            default: bus.pc_rst = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Scoreboard bench for sisc_ctrl: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_sisc_ctrl;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;
    localparam int PH_WB     = 4;
    localparam int PH_START  = 5;
    localparam int PH_HALT   = 6;

`ifdef SISC_CTRL_IMM_ALU_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] aluOp;
        logic       irLoad;
        logic       pcWrite;
        logic       pcSel;
        logic       brSel;
        logic       pcRst;
        logic       rbSel;
        logic       rfWe;
        logic       wbSel;
        logic       dmWe;
        logic       halted;
    } outVec_t;

    typedef struct {
        outVec_t vec;
        string   name;
    } scoreItem_t;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    scoreItem_t scoreQ[$];

    sisc_ctrl_if bus ();

    sisc_ctrl #(
        .OPW (4),
        .MMW (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle, derived straight from the opcode table and phase rules
    function automatic outVec_t modelOut(input logic [31:0] ins, input logic [3:0] st, input int phase);
        outVec_t o;
        logic [3:0] op;
        logic [3:0] mm;
        logic [1:0] aluSel;
        bit isStr, isLod, isReg, isImm, taken;
        op    = ins[31:28];
        mm    = ins[27:24];
        isStr = (op == 4'h3);
        isLod = (op == 4'h2);
        isReg = (op == 4'h1);
        isImm = IMM_EN && (op == 4'h9);
        if (isReg)              aluSel = 2'b00;
        else if (isImm)         aluSel = 2'b01;
        else if (isLod || isStr) aluSel = 2'b11;
        else                    aluSel = 2'b10;
        if (op == 4'h4 || op == 4'h5)      taken = (mm == 4'd0) || ((mm & st) != 4'd0);
        else if (op == 4'h6 || op == 4'h7) taken = ((mm & st) == 4'd0);
        else                               taken = 1'b0;
        o = '0;
        o.aluOp = 2'b10;
        case (phase)
            PH_START: o.pcRst = 1'b1;
            PH_FETCH: begin
                o.irLoad  = 1'b1;
                o.pcWrite = 1'b1;
            end
            PH_DECODE: o.rbSel = isStr;
            PH_EXEC: begin
                o.aluOp = aluSel;
                o.rbSel = isStr;
            end
            PH_MEM: begin
                o.aluOp = aluSel;
                o.rbSel = isStr;
                o.dmWe  = isStr;
                if (taken) begin
                    o.pcWrite = 1'b1;
                    o.pcSel   = 1'b1;
                    o.brSel   = op[0];
                end
            end
            PH_WB: begin
                o.aluOp = aluSel;
                o.rbSel = isStr;
                o.rfWe  = isReg || isImm || isLod;
                o.wbSel = isLod;
            end
            PH_HALT: o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic checkOutput(input outVec_t act, input outVec_t exp, input string nm);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b expected %b (aluOp,irLd,pcWr,pcSel,brSel,pcRst,rbSel,rfWe,wbSel,dmWe,halted)",
                     nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs, queue what the DUT should show this cycle, then advance
    task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] st, input logic r,
                                 input int phase, input string nm);
        scoreItem_t item;
        rst       = r;
        bus.instr = ins;
        bus.stat  = st;
        item.vec  = modelOut(ins, st, phase);
        item.name = $sformatf("%s/ph%0d/%h", nm, phase, ins);
        scoreQ.push_back(item);
        @(posedge clk);
        #1;
    endtask

    task automatic runInstr(input logic [31:0] ins, input logic [3:0] st, input bit randStat,
                            input int rstAt, input string nm);
        logic [3:0] s;
        for (int k = 0; k < 5; k++) begin
            s = randStat ? 4'($urandom) : st;
            applyStimulus(ins, s, (k == rstAt), k, nm);
            if (k == rstAt) begin
                applyStimulus(ins, s, 1'b0, PH_START, {nm, "-rst"});
                return;
            end
        end
    endtask

    task automatic runHalt(input int holdCycles);
        applyStimulus(32'hF000_0000, 4'h0, 1'b0, PH_FETCH, "hlt");
        applyStimulus(32'hF000_0000, 4'h0, 1'b0, PH_DECODE, "hlt");
        for (int k = 0; k < holdCycles; k++)
            applyStimulus(32'hF000_0000, 4'($urandom), 1'b0, PH_HALT, "hlt-hold");
        applyStimulus(32'hF000_0000, 4'h0, 1'b1, PH_HALT, "hlt-rst");
        applyStimulus(32'h0000_0000, 4'h0, 1'b0, PH_START, "hlt-start");
    endtask

    initial begin : monitor
        outVec_t act;
        scoreItem_t item;
        forever begin
            @(negedge clk);
            if (scoreQ.size() > 0) begin
                item = scoreQ.pop_front();
                act  = {bus.alu_op, bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel, bus.pc_rst,
                        bus.rb_sel, bus.rf_we, bus.wb_sel, bus.dm_we, bus.halted};
                checkOutput(act, item.vec, item.name);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] ins;
        int rstAt;
        testsRun    = 0;
        testsFailed = 0;
        rst       = 1'b1;
        bus.instr = 32'h0;
        bus.stat  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(32'h0, 4'h0, 1'b0, PH_START, "reset");

        runInstr(32'h0000_0000, 4'h0, 1'b0, -1, "nop");
        runInstr(32'h0000_0000, 4'h0, 1'b0, -1, "nop2");
        runInstr(32'h1123_0001, 4'h0, 1'b0, -1, "add");
        runInstr(32'h2120_0004, 4'h0, 1'b0, -1, "lod");
        runInstr(32'h3120_0004, 4'h0, 1'b0, -1, "str");
        runInstr(32'h4100_0020, 4'h1, 1'b0, -1, "bra-taken");
        runInstr(32'h4100_0020, 4'h0, 1'b0, -1, "bra-not");
        runInstr(32'h4000_0020, 4'h0, 1'b0, -1, "bra-mm0");
        runInstr(32'h7100_0010, 4'h0, 1'b0, -1, "bnr-taken");
        runInstr(32'h6100_0010, 4'h1, 1'b0, -1, "bne-not");
        runInstr(32'h5C00_0010, 4'h4, 1'b0, -1, "brr-taken");
        runInstr(32'h9120_0005, 4'h0, 1'b0, -1, "ali");
        runInstr(32'hA120_0005, 4'h0, 1'b0, -1, "unknown");
        runInstr(32'h3120_0004, 4'h0, 1'b0, PH_MEM, "str-rstmem");
        runHalt(20);

        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            if (ins[31:28] == 4'hF) ins[31:28] = 4'h0;
            rstAt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            runInstr(ins, 4'h0, 1'b1, rstAt, "rand");
        end

        @(negedge clk);
        #1;
        testsRun++;
        if (scoreQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending expected 0", scoreQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sisc_ctrl.md
Name: sisc_ctrl

Overview:
- Multi-cycle control unit for the SISC processor; it is the initiator side of the ALU interface.
- Decodes the 32-bit instruction word and drives alu_op, register-file, data-memory and PC controls.
- Consumes the registered 4-bit status (C,V,N,Z) to resolve conditional branches.
- Sequences every instruction through fixed FETCH/DECODE/EXECUTE/MEM/WRITEBACK states, matching the ALU's one-cycle registered result.

Parameters:
- OPW, 4, opcode field width (instr[31:28]).
- MMW, 4, branch mask field width (instr[27:24]).

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- instr  input  32  current instruction register contents; opcode [31:28], mm [27:24], rd [23:20], rs [19:16], rt [15:12], imm [15:0]
- stat  input  4  registered status: [3]=C, [2]=V, [1]=N, [0]=Z
- alu_op  output  2  [1]=non-arithmetic (suppress status save), [0]=use sign-extended imm as operand B
- ir_load  output  1  latch instruction memory output into IR
- pc_write  output  1  PC register load enable
- pc_sel  output  1  0=PC+1, 1=branch target
- br_sel  output  1  0=absolute target (imm), 1=relative target (PC+imm)
- pc_rst  output  1  force PC to 0
- rb_sel  output  1  register-file read port B selects rd (1, for STR data) instead of rt (0)
- rf_we  output  1  register-file write enable
- wb_sel  output  1  writeback source: 0=alu_result, 1=data memory
- dm_we  output  1  data-memory write enable
- halted  output  1  high in HALT state

Behaviour:
- Opcodes:
  - 0x0 NOP.
  - 0x1 ALU register op (function in imm[3:0]).
  - 0x2 LOD: rd = M[rs+imm].
  - 0x3 STR: M[rs+imm] = rd.
  - 0x4 BRA (absolute), 0x5 BRR (relative): taken if mm==0 or (mm & stat)!=0.
  - 0x6 BNE (absolute), 0x7 BNR (relative): taken if (mm & stat)==0.
  - 0x9 ALU immediate: rd = rs + sext(imm).
  - 0xF HLT.
  - All others execute as NOP.
- State register transitions:
  - START -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK -> FETCH.
  - HALT is entered from DECODE when opcode==0xF.
  - Every non-HLT instruction takes exactly 5 cycles.
- Reset:
  - rst sampled high on posedge: state=START next cycle, whatever the current state (including HALT and mid-instruction).
  - In START: pc_rst=1 and all other outputs 0, alu_op=2'b10.
- Outputs are combinational from the registered state and instr; defaults are 0 and alu_op=2'b10.
  - FETCH: ir_load=1, pc_write=1, pc_sel=0.
  - DECODE: no enables asserted. rb_sel=1 if opcode==STR.
  - EXECUTE: alu_op=00 for 0x1, 01 for 0x9, 11 for LOD/STR; otherwise 10. rb_sel held.
  - MEM: alu_op held from EXECUTE. dm_we=1 for STR. For a taken branch: pc_write=1, pc_sel=1, br_sel=opcode[0].
  - WRITEBACK: rf_we=1 for 0x1, 0x9 and LOD. wb_sel=1 for LOD. alu_op held.
- Branch condition uses stat sampled in MEM; status saved by the preceding ALU instruction is therefore visible.
- HALT: halted=1, all enables 0; remain in HALT until rst.
- Every multi-bit arithmetic operation is external to this block; this block performs no width arithmetic.

Optional Feature:
- Macro: SISC_CTRL_IMM_ALU_EN.
- Defined: opcode 0x9 decodes as ALU immediate (alu_op=01 in EXECUTE, rf_we in WRITEBACK).
- Undefined: 0x9 is an unknown opcode and executes as a 5-cycle NOP with no rf_we.

Decomposition:
- Shared package sisc_pkg holds:
  - opcode constants (OP_NOP..OP_HLT)
  - state encoding typedef (START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT)
  - alu_op encodings (ALUOP_REG=00, ALUOP_IMM=01, ALUOP_NONE=10, ALUOP_ADDR=11)
  - status bit indices
- One sub-module, sisc_br_cond: combinational, inputs opcode/mm/stat, output taken.

Test Plan:
1. Reset, then instr=0x00000000 for 10 cycles -> pc_rst=1 only in START; ir_load/pc_write pulse at cycles 1 and 6; rf_we never high.
2. instr=0x11230001 (ADD r1=r2+r3) -> EXECUTE alu_op=00; WRITEBACK rf_we=1, wb_sel=0; no other enables.
3. instr=0x21200004 (LOD r1,[r2+4]) -> EXECUTE alu_op=11; WRITEBACK rf_we=1, wb_sel=1. instr=0x31200004 (STR) -> DECODE..WRITEBACK rb_sel=1; MEM dm_we=1; rf_we=0.
4. instr=0x41000020 with stat=0001 (mm=0001) -> MEM pc_write=1, pc_sel=1, br_sel=0. Same with stat=0000 -> pc_write=0 in MEM. instr=0x71000010, stat=0000 -> taken, br_sel=1.
5. instr=0xF0000000 -> halted=1 from cycle after DECODE, held 20 cycles. Assert rst -> START next cycle, halted=0.
6. Assert rst during MEM of STR -> dm_we low in the following cycle, state START. instr=0x91200005 -> alu_op=01 and rf_we with macro defined; alu_op=10 and no rf_we without it.
